// File: rtl/iram_loader_if.sv
// Fetch and byte-stream load signals of the instruction RAM.
// The CPU/loader side uses master, the memory uses slave.
interface iram_loader_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 10
);
    localparam int IW = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] q;
    logic              ready;
    logic              ld_start;
    logic [IW-1:0]     ld_base;
    logic              ld_valid;
    logic [7:0]        ld_byte;
    logic              ld_last;
    logic              ld_accept;
    logic              ld_done;
    logic              ld_err;
    logic [IW:0]       ld_count;

    modport master (
        output addr, ld_start, ld_base, ld_valid, ld_byte, ld_last,
        input  q, ready, ld_accept, ld_done, ld_err, ld_count
    );

    modport slave (
        input  addr, ld_start, ld_base, ld_valid, ld_byte, ld_last,
        output q, ready, ld_accept, ld_done, ld_err, ld_count
    );
endinterface

// File: rtl/iram_loader.sv
// Runtime-loadable instruction RAM: zero sweep after reset, big-endian
// byte-stream programming, combinational fetch gated by READY.
module iram_loader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 10
) (
    input logic         clk,
    input logic         reset,
    iram_loader_if.slave bus
);
    localparam int BPW = DATA_W / 8;
    localparam int IW  = $clog2(DEPTH);
    localparam int BW  = $clog2(BPW);
    localparam int BCW = (BPW > 1) ? BW : 1;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD, S_DRAIN} state_t;

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [BCW-1:0]    bcnt;
    logic [DATA_W-1:0] asm_word;
    logic              err;
    logic              done;
    logic [IW:0]       count;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              take;
    logic              word_end;
    logic              we;
    logic [DATA_W-1:0] next_word;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W:0]   widx;

    function automatic logic [DATA_W-1:0] place_byte(
        input logic [DATA_W-1:0] w,
        input logic [7:0]        b,
        input logic [BCW-1:0]    k
    );
        logic [DATA_W-1:0] r;
        r = w;
        for (int i = 0; i < BPW; i++) begin
            if (BCW'(i) == k) r[DATA_W-1-8*i -: 8] = b;
        end
        return r;
    endfunction

    assign take      = (state == S_LOAD) && bus.ld_valid;
    assign word_end  = (bcnt == BCW'(BPW-1)) || bus.ld_last;
    assign next_word = place_byte(asm_word, bus.ld_byte, bcnt);

    // The clear sweep and load writes share ptr as the write address
    always_comb begin
        we    = 1'b0;
        wdata = next_word;
        if (!reset) begin
            if (state == S_CLEAR) begin
                we    = 1'b1;
                wdata = '0;
            end else if (take && word_end) begin
                we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[ptr] <= wdata;
    end

    // Low bytes stay zero between words, which gives the LD_LAST padding
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.ld_start) asm_word <= '0;
        else if (take)                       asm_word <= word_end ? '0 : next_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_CLEAR;
            ptr   <= '0;
            bcnt  <= '0;
            err   <= 1'b0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == IW'(DEPTH-1)) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (bus.ld_start) begin
                        ptr   <= bus.ld_base;
                        bcnt  <= '0;
                        count <= '0;
                        err   <= 1'b0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.ld_valid) begin
                        if (word_end) begin
                            bcnt <= '0;
                            if (count != (IW+1)'(DEPTH)) count <= count + 1'b1;
                            if (bus.ld_last) begin
                                state <= S_IDLE;
                                done  <= 1'b1;
                            end else if (ptr == IW'(DEPTH-1)) begin
                                err   <= 1'b1;
                                state <= S_DRAIN;
                            end else begin
                                ptr <= ptr + 1'b1;
                            end
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.ld_valid && bus.ld_last) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    assign bus.ready     = (state == S_IDLE);
    assign bus.ld_accept = (state == S_LOAD) || (state == S_DRAIN);
    assign bus.ld_done   = done;
    assign bus.ld_err    = err;
    assign bus.ld_count  = count;

    // One extra bit so indices at or beyond DEPTH are detectable
    assign widx  = {1'b0, bus.addr} >> BW;
    assign bus.q = (bus.ready && (widx < (ADDR_W+1)'(DEPTH))) ? mem[widx[IW-1:0]] : '0;
endmodule

// File: tb/tb_iram_loader.sv
// Randomised and directed bench for iram_loader against a load-level model.
module tb_iram_loader;
    localparam int DEPTH = 512;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    iram_loader_if #(.DATA_W(16), .DEPTH(DEPTH), .ADDR_W(10)) bus ();
    iram_loader_if #(.DATA_W(16), .DEPTH(DEPTH), .ADDR_W(11)) bus2 ();

    iram_loader #(.DATA_W(16), .DEPTH(DEPTH), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    iram_loader #(.DATA_W(16), .DEPTH(DEPTH), .ADDR_W(11)) dut_wide (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    assign bus2.ld_start = bus.ld_start;
    assign bus2.ld_base  = bus.ld_base;
    assign bus2.ld_valid = bus.ld_valid;
    assign bus2.ld_byte  = bus.ld_byte;
    assign bus2.ld_last  = bus.ld_last;

    typedef logic [7:0] bq_t[$];
    typedef enum {P_CLEAR, P_IDLE, P_LOAD} phase_t;

    phase_t      m_phase;
    int          clear_left;
    logic [15:0] mmem [DEPTH];
    logic [8:0]  m_base;
    bq_t         ldq;
    logic        m_done;
    logic        m_err;
    int          m_count;

    int          checks = 0;
    int          errors = 0;
    logic        pin_en = 1'b0;
    int          pin_sel;
    logic [15:0] pin_exp;
    string       pin_name;
    logic        rand_addr;

    task automatic m_reset();
        m_phase    = P_CLEAR;
        clear_left = DEPTH;
        m_err      = 1'b0;
        m_count    = 0;
        m_done     = 1'b0;
        ldq.delete();
        for (int i = 0; i < DEPTH; i++) mmem[i] = 16'h0000;
    endtask

    // Whole load applied at once: bytes pair up big-endian into words from base
    task automatic m_apply();
        int n, need, avail, nw;
        logic [7:0] lo;
        n     = ldq.size();
        need  = (n + 1) / 2;
        avail = DEPTH - int'(m_base);
        nw    = (need > avail) ? avail : need;
        m_err   = (need > avail);
        m_count = nw;
        for (int w = 0; w < nw; w++) begin
            lo = (2*w + 1 < n) ? ldq[2*w+1] : 8'h00;
            mmem[int'(m_base) + w] = {ldq[2*w], lo};
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_reset();
            end else begin
                m_done = 1'b0;
                case (m_phase)
                    P_CLEAR: begin
                        clear_left--;
                        if (clear_left == 0) m_phase = P_IDLE;
                    end
                    P_IDLE: begin
                        if (bus.ld_start) begin
                            m_base = bus.ld_base;
                            ldq.delete();
                            m_phase = P_LOAD;
                        end
                    end
                    default: begin
                        if (bus.ld_valid) begin
                            ldq.push_back(bus.ld_byte);
                            if (bus.ld_last) begin
                                m_apply();
                                m_phase = P_IDLE;
                                m_done  = 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        int          idx, idx2;
        logic        er;
        logic [15:0] eq, eq2;
        forever begin
            @(negedge clk);
            er   = (m_phase == P_IDLE);
            idx  = int'(bus.addr) >> 1;
            idx2 = int'(bus2.addr) >> 1;
            eq   = er ? mmem[idx] : 16'h0000;
            eq2  = (er && idx2 < DEPTH) ? mmem[idx2] : 16'h0000;
            cmp("ready",     32'(bus.ready),     32'(er));
            cmp("ld_accept", 32'(bus.ld_accept), 32'(m_phase == P_LOAD));
            cmp("ld_done",   32'(bus.ld_done),   32'(m_done));
            cmp("q",         32'(bus.q),         32'(eq));
            cmp("q_wide",    32'(bus2.q),        32'(eq2));
            if (er) begin
                cmp("ld_err",   32'(bus.ld_err),   32'(m_err));
                cmp("ld_count", 32'(bus.ld_count), 32'(m_count));
            end
            if (pin_en) begin
                case (pin_sel)
                    0:       cmp(pin_name, 32'(bus.q),        32'(pin_exp));
                    1:       cmp(pin_name, 32'(bus2.q),       32'(pin_exp));
                    2:       cmp(pin_name, 32'(bus.ld_count), 32'(pin_exp));
                    3:       cmp(pin_name, 32'(bus.ld_err),   32'(pin_exp));
                    default: cmp(pin_name, 32'(bus.ready),    32'(pin_exp));
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        pin_en       = 1'b0;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        if (rand_addr) begin
            bus.addr  = 10'($urandom_range(0, 1023));
            bus2.addr = 11'($urandom_range(0, 2047));
        end
    endtask

    task automatic pin(input int sel, input int a, input logic [15:0] e, input string nm);
        step();
        bus.addr  = 10'(a);
        bus2.addr = 11'(a);
        pin_sel   = sel;
        pin_exp   = e;
        pin_name  = nm;
        pin_en    = 1'b1;
    endtask

    task automatic wait_ready(input int budget);
        int k = 0;
        while (!bus.ready && k < budget) begin
            step();
            k++;
        end
        pin(4, 0, 16'h1, "ready_wait");
    endtask

    task automatic load(input int base, input bq_t b, input int stall_max, input bit noise);
        step();
        bus.ld_start = 1'b1;
        bus.ld_base  = 9'(base);
        for (int i = 0; i < b.size(); i++) begin
            int s = $urandom_range(0, stall_max);
            repeat (s) begin
                step();
                if (noise && i > 0) begin
                    bus.ld_start = 1'b1;
                    bus.ld_base  = 9'($urandom);
                end
                bus.ld_byte = 8'($urandom);
            end
            step();
            bus.ld_valid = 1'b1;
            bus.ld_byte  = b[i];
            bus.ld_last  = (i == b.size() - 1);
        end
        step();
    endtask

    task automatic sweep();
        rand_addr = 1'b0;
        for (int a = 0; a < 1024; a++) begin
            step();
            bus.addr  = 10'(a);
            bus2.addr = 11'(a + 1024);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t b;
        int  base, n;
        bus.addr     = '0;
        bus2.addr    = '0;
        bus.ld_start = 1'b0;
        bus.ld_base  = '0;
        bus.ld_valid = 1'b0;
        bus.ld_byte  = '0;
        bus.ld_last  = 1'b0;
        rand_addr    = 1'b1;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        wait_ready(600);
        sweep();

        b = {8'hF0, 8'h08, 8'hF0, 8'h10};
        load(5, b, 0, 1'b0);
        wait_ready(10);
        pin(0, 10, 16'hF008, "full_w5");
        pin(0, 12, 16'hF010, "full_w6");
        pin(2, 0, 16'd2, "full_count");
        pin(3, 0, 16'd0, "full_err");

        b = {8'h12, 8'h34, 8'h56};
        load(0, b, 0, 1'b0);
        wait_ready(10);
        pin(0, 0, 16'h1234, "part_w0");
        pin(0, 2, 16'h5600, "part_w1");
        pin(2, 0, 16'd2, "part_count");

        pin(1, 1024, 16'h0000, "oor_1024");
        pin(1, 0, 16'h1234, "wide_w0");

        b = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        load(511, b, 0, 1'b0);
        wait_ready(10);
        pin(0, 1022, 16'hAABB, "ovr_w511");
        pin(0, 0, 16'h1234, "ovr_w0_kept");
        pin(3, 0, 16'd1, "ovr_err");
        pin(2, 0, 16'd1, "ovr_count");

        step();
        bus.ld_start = 1'b1;
        bus.ld_base  = 9'd20;
        step(); bus.ld_valid = 1'b1; bus.ld_byte = 8'h01;
        step();
        step(); bus.ld_start = 1'b1; bus.ld_base = 9'd100;
        step();
        step();
        step(); bus.ld_valid = 1'b1; bus.ld_byte = 8'h02;
        step(); bus.ld_valid = 1'b1; bus.ld_byte = 8'h03; bus.ld_last = 1'b1;
        step();
        wait_ready(10);
        pin(0, 40, 16'h0102, "stall_w20");
        pin(0, 42, 16'h0300, "stall_w21");
        pin(0, 200, 16'h0000, "stall_w100");
        pin(2, 0, 16'd2, "stall_count");

        rand_addr = 1'b1;
        step();
        bus.ld_start = 1'b1;
        bus.ld_base  = 9'd30;
        for (int i = 0; i < 3; i++) begin
            step();
            bus.ld_valid = 1'b1;
            bus.ld_byte  = 8'($urandom_range(1, 255));
        end
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        wait_ready(600);
        sweep();

        rand_addr = 1'b1;
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 3)) begin
                step();
                bus.ld_valid = 1'($urandom);
                bus.ld_last  = 1'($urandom);
                bus.ld_byte  = 8'($urandom);
            end
            base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(508, 511))
                                               : int'($urandom_range(0, 511));
            n = $urandom_range(1, 7);
            b.delete();
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            load(base, b, 2, 1'b1);
            wait_ready(20);
        end

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/iram_loader.md
# iram_loader

Parametrised, runtime-loadable instruction memory for the soft CPU. It replaces the hard-coded, reset-initialised program ROM with a RAM that is zeroed by a hardware sweep after reset. The array is then programmed through a byte-stream valid/ready port, so a new program can be loaded without resynthesis. The CPU fetch side keeps the existing combinational byte-addressed read, plus a READY qualifier that stalls fetch while the array is being cleared or loaded.

## Interface
- DATA_W, 16: instruction word width; must be a multiple of 8 (BPW = DATA_W/8 bytes per word, power of two).
- DEPTH, 512: number of words; power of two.
- ADDR_W, 10: fetch byte-address width; must satisfy ADDR_W ≥ log2(DEPTH)+log2(BPW).
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ADDR  in  ADDR_W  fetch byte address; word index = ADDR >> log2(BPW), low bits ignored.
- Q  out  DATA_W  fetched instruction word (combinational).
- READY  out  1  high only in IDLE; the CPU must hold its PC while low.
- LD_START  in  1  one-cycle request to begin a load; sampled only in IDLE.
- LD_BASE  in  log2(DEPTH)  first word index of the load, captured with LD_START.
- LD_VALID  in  1  byte present on LD_BYTE.
- LD_BYTE  in  8  load data byte.
- LD_LAST  in  1  qualifies the final byte of the load (valid with LD_VALID).
- LD_ACCEPT  out  1  ready for the byte stream; a byte transfers when LD_VALID & LD_ACCEPT.
- LD_DONE  out  1  one-cycle pulse on return to IDLE after a load.
- LD_ERR  out  1  sticky: load overran word DEPTH-1; cleared by the next accepted LD_START or by RESET.
- LD_COUNT  out  log2(DEPTH)+1  number of words written by the most recent load.

## Operation
- States: CLEAR, IDLE, LOAD, DRAIN.
- RESET forces CLEAR, with the clear pointer at 0, and clears LD_ERR, LD_COUNT and the byte counter.
- CLEAR: writes 0 to mem[ptr] each cycle and increments ptr. After writing DEPTH-1, goes to IDLE.
- IDLE: READY=1. On LD_START, captures LD_BASE into the write pointer, zeros the byte counter, the assembly register and LD_COUNT, clears LD_ERR, and goes to LOAD.
- LOAD: LD_ACCEPT=1.
  - Each accepted byte is placed big-endian: byte k of a word goes to bits [DATA_W-1-8k -: 8].
  - After byte BPW-1 is accepted, the word is written at the pointer; the pointer and LD_COUNT increment and the byte counter returns to 0.
  - If LD_LAST arrives mid-word, the remaining low bytes are padded with 0 and the word is written.
  - After the write caused by LD_LAST, the block goes to IDLE and pulses LD_DONE.
  - If a word completes at index DEPTH-1 and LD_LAST is not set, LD_ERR is set and the block goes to DRAIN. The pointer never wraps.
- DRAIN: LD_ACCEPT=1. Accepted bytes are discarded with no writes. An accepted byte with LD_LAST goes to IDLE with an LD_DONE pulse.
- Fetch read: Q = mem[word index] when READY=1 and word index < DEPTH; otherwise Q = 0.
- LD_START is ignored outside IDLE. LD_VALID without LD_ACCEPT has no effect.

## Timing
- Reset values: READY=0, LD_ACCEPT=0, LD_DONE=0, LD_ERR=0, LD_COUNT=0, Q=0.
- CLEAR lasts exactly DEPTH cycles after RESET deasserts. READY rises at the edge ending cycle DEPTH.
- LD_START in cycle n: READY=0 and LD_ACCEPT=1 from cycle n+1.
- The word write happens at the same edge as the accepting transfer of its final or LD_LAST byte.
- That edge also moves LOAD to IDLE. LD_DONE=1 and READY=1 in the following cycle, and the new contents are visible on Q then.
- One byte can be accepted per cycle with no bubbles. LD_ACCEPT stays high continuously through LOAD and DRAIN.
- RESET mid-LOAD or mid-CLEAR aborts immediately. No further writes occur, and CLEAR restarts from index 0.
- LD_COUNT holds until the next LD_START and saturates logically at DEPTH.

## Test plan
- Reset, then probe every address with DATA_W=16, DEPTH=512:
  - READY stays 0 for 512 cycles, then goes to 1.
  - Every ADDR reads Q=0x0000.
  - LD_ACCEPT stays 0 throughout.
- Full-word load:
  - Stimulus: LD_START with LD_BASE=5, then bytes F0,08,F0,10 with LD_LAST on the last byte, one per cycle.
  - Response: ADDR=10 reads 0xF008 and ADDR=12 reads 0xF010; LD_COUNT=2; one LD_DONE pulse; LD_ERR=0.
- Partial-word load:
  - Stimulus: LD_BASE=0, bytes 12,34,56 with LD_LAST on 56.
  - Response: mem[0]=0x1234 and mem[1]=0x5600; LD_COUNT=2.
- Overrun:
  - Stimulus: LD_BASE=511, bytes AA,BB,CC,DD,EE with LD_LAST on EE.
  - Response: mem[511]=0xAABB; mem[0] is unchanged; LD_ERR=1; LD_DONE pulses after EE; LD_COUNT=1.
- Reset during LOAD:
  - Stimulus: assert RESET after 3 of 6 bytes.
  - Response: all outputs return to their reset values; the full 512-cycle CLEAR repeats; every word reads 0 afterwards.
- Stall and ignored start:
  - Stimulus: during LOAD, deassert LD_VALID for 4 cycles and pulse LD_START mid-load.
  - Response: no extra writes; the base address is unchanged; the word is assembled correctly; READY stays 0 until done.
- Out-of-range fetch:
  - Stimulus: ADDR_W=11 build with ADDR=1024.
  - Response: Q=0.
